// File: rtl/kdtree_input_loader.sv
// kd-tree input loader: parses the input FIFO word stream into
// internal-node, leaf-patch and query-patch memory writes.
module kdtree_input_loader #(
    parameter int DATA_WIDTH = 11,
    parameter int PATCH_SIZE = 5,
    parameter int LEAF_SIZE  = 8,
    parameter int NUM_LEAVES = 64,
    parameter int NUM_QUERYS = 494,
    parameter int IDX_WIDTH  = 3
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             load_kdtree,
    input  logic                             fifo_rempty_n,
    input  logic [DATA_WIDTH-1:0]            fifo_rdata,
    output logic                             fifo_deq,
    output logic                             node_wen,
    output logic [5:0]                       node_waddr,
    output logic [IDX_WIDTH-1:0]             node_wdata_idx,
    output logic [DATA_WIDTH-1:0]            node_wdata_median,
    output logic                             leaf_wen,
    output logic [5:0]                       leaf_waddr,
    output logic [2:0]                       leaf_wpatch,
    output logic [PATCH_SIZE*DATA_WIDTH-1:0] leaf_wdata_patch,
    output logic [DATA_WIDTH-1:0]            leaf_wdata_idx,
    output logic                             query_wen,
    output logic [8:0]                       query_waddr,
    output logic [PATCH_SIZE*DATA_WIDTH-1:0] query_wdata,
    output logic                             loading,
    output logic                             load_done
);

    localparam int PW = PATCH_SIZE * DATA_WIDTH;

    localparam logic [5:0] LAST_NODE  = 6'(NUM_LEAVES - 2);
    localparam logic [5:0] LAST_LEAF  = 6'(NUM_LEAVES - 1);
    localparam logic [2:0] LAST_PATCH = 3'(LEAF_SIZE - 1);
    localparam logic [8:0] LAST_QUERY = 9'(NUM_QUERYS - 1);
    localparam logic [2:0] LEAF_LAST_WORD  = 3'(PATCH_SIZE);
    localparam logic [2:0] QUERY_LAST_WORD = 3'(PATCH_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_NODE,
        S_LEAF,
        S_QUERY,
        S_DONE
    } state_t;

    state_t               state;
    logic [2:0]           word_cnt;
    logic [5:0]           node_cnt;
    logic [5:0]           leaf_cnt;
    logic [2:0]           patch_cnt;
    logic [8:0]           query_cnt;
    logic [IDX_WIDTH-1:0] idx_q;
    logic [PW-1:0]        elem_q;

    assign loading  = (state == S_NODE) || (state == S_LEAF) ||
                      (state == S_QUERY);
    assign fifo_deq = loading && fifo_rempty_n && !load_kdtree;

    // Parser FSM: consumes one word per pop, emits one registered write per record.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= S_IDLE;
            word_cnt          <= '0;
            node_cnt          <= '0;
            leaf_cnt          <= '0;
            patch_cnt         <= '0;
            query_cnt         <= '0;
            idx_q             <= '0;
            elem_q            <= '0;
            node_wen          <= 1'b0;
            node_waddr        <= '0;
            node_wdata_idx    <= '0;
            node_wdata_median <= '0;
            leaf_wen          <= 1'b0;
            leaf_waddr        <= '0;
            leaf_wpatch       <= '0;
            leaf_wdata_patch  <= '0;
            leaf_wdata_idx    <= '0;
            query_wen         <= 1'b0;
            query_waddr       <= '0;
            query_wdata       <= '0;
            load_done         <= 1'b0;
        end else begin
            node_wen  <= 1'b0;
            leaf_wen  <= 1'b0;
            query_wen <= 1'b0;
            // done flag lags entry into DONE so it follows the final write
            load_done <= (state == S_DONE) && !load_kdtree;
            if (load_kdtree) begin
                state     <= S_NODE;
                word_cnt  <= '0;
                node_cnt  <= '0;
                leaf_cnt  <= '0;
                patch_cnt <= '0;
                query_cnt <= '0;
                idx_q     <= '0;
                elem_q    <= '0;
            end else if (fifo_deq) begin
                unique case (state)
                    S_NODE: begin
                        if (word_cnt == 3'd0) begin
                            idx_q    <= fifo_rdata[IDX_WIDTH-1:0];
                            word_cnt <= 3'd1;
                        end else begin
                            node_wen          <= 1'b1;
                            node_waddr        <= node_cnt;
                            node_wdata_idx    <= idx_q;
                            node_wdata_median <= fifo_rdata;
                            word_cnt          <= 3'd0;
                            node_cnt          <= node_cnt + 6'd1;
                            if (node_cnt == LAST_NODE) begin
                                state <= S_LEAF;
                            end
                        end
                    end
                    S_LEAF: begin
                        if (word_cnt == LEAF_LAST_WORD) begin
                            leaf_wen         <= 1'b1;
                            leaf_waddr       <= leaf_cnt;
                            leaf_wpatch      <= patch_cnt;
                            leaf_wdata_patch <= elem_q;
                            leaf_wdata_idx   <= fifo_rdata;
                            word_cnt         <= 3'd0;
                            if (patch_cnt == LAST_PATCH) begin
                                patch_cnt <= 3'd0;
                                leaf_cnt  <= leaf_cnt + 6'd1;
                                if (leaf_cnt == LAST_LEAF) begin
                                    state <= S_QUERY;
                                end
                            end else begin
                                patch_cnt <= patch_cnt + 3'd1;
                            end
                        end else begin
                            for (int k = 0; k < PATCH_SIZE; k++) begin
                                if (word_cnt == 3'(k)) begin
                                    elem_q[k*DATA_WIDTH +: DATA_WIDTH] <= fifo_rdata;
                                end
                            end
                            word_cnt <= word_cnt + 3'd1;
                        end
                    end
                    S_QUERY: begin
                        if (word_cnt == QUERY_LAST_WORD) begin
                            query_wen   <= 1'b1;
                            query_waddr <= query_cnt;
                            query_wdata <= {fifo_rdata, elem_q[PW-DATA_WIDTH-1:0]};
                            word_cnt    <= 3'd0;
                            query_cnt   <= query_cnt + 9'd1;
                            if (query_cnt == LAST_QUERY) begin
                                state <= S_DONE;
                            end
                        end else begin
                            for (int k = 0; k < PATCH_SIZE; k++) begin
                                if (word_cnt == 3'(k)) begin
                                    elem_q[k*DATA_WIDTH +: DATA_WIDTH] <= fifo_rdata;
                                end
                            end
                            word_cnt <= word_cnt + 3'd1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/kdtree_input_loader.md
Name: kdtree_input_loader

Overview:
Sits between the read side of the input FIFO (fed 11-bit words from the IO pads) and the on-chip storage: internal-node memory, leaf memory and query-patch memory. After a load_kdtree pulse it parses the word stream in fixed order: internal nodes, then leaves, then query patches. It assembles each multi-word record and issues one registered write strobe per record. It raises load_done when the last query patch has been written.

Parameters:
DATA_WIDTH, 11, width of one stream word / one patch element
PATCH_SIZE, 5, elements per patch
LEAF_SIZE, 8, patches per leaf
NUM_LEAVES, 64, leaves in tree; NUM_NODES = NUM_LEAVES-1 (63)
NUM_QUERYS, 494, query patches (26x19)
IDX_WIDTH, 3, width of the node split-dimension field

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
load_kdtree  in  1  single-cycle start pulse; (re)starts parsing at internal nodes
fifo_rempty_n  in  1  input FIFO non-empty; fifo_rdata valid when high (first-word-fall-through)
fifo_rdata  in  DATA_WIDTH  head word of input FIFO
fifo_deq  out  1  pop head word this cycle
node_wen  out  1  internal-node write strobe
node_waddr  out  6  node index 0..62
node_wdata_idx  out  IDX_WIDTH  split dimension (low IDX_WIDTH bits of word 0)
node_wdata_median  out  DATA_WIDTH  median (word 1)
leaf_wen  out  1  leaf-patch write strobe
leaf_waddr  out  6  leaf number 0..63
leaf_wpatch  out  3  patch slot within leaf 0..7
leaf_wdata_patch  out  PATCH_SIZE*DATA_WIDTH  patch elements; element k at [k*11 +: 11]
leaf_wdata_idx  out  DATA_WIDTH  original-image patch index (word 5)
query_wen  out  1  query-patch write strobe
query_waddr  out  9  query number 0..493
query_wdata  out  PATCH_SIZE*DATA_WIDTH  query elements, same packing as leaf
loading  out  1  high in NODE/LEAF/QUERY states
load_done  out  1  high in DONE state

Behaviour:
- States: IDLE, NODE, LEAF, QUERY, DONE. Reset value: IDLE. All counters 0. All outputs 0.
- load_kdtree=1 in any state goes to NODE next cycle and clears all counters and partial-record registers. fifo_deq is forced 0 in that cycle.
- Handshake: fifo_deq = loading && fifo_rempty_n && !load_kdtree, combinational. A word is consumed only in a cycle where fifo_deq=1. No pop in IDLE or DONE; words there remain in the FIFO.
- NODE: 2 words per node. Word 0 (index) is latched. Word 1 (median) completes the record. After the 63rd node, go to LEAF.
- LEAF: 6 words per patch. Words 0..4 are elements 0..4; word 5 is the patch index. Patch counter 0..7 within a leaf; leaf counter 0..63. After leaf 63 patch 7, go to QUERY.
- QUERY: 5 words per patch. After query NUM_QUERYS-1, go to DONE.
- Write latency: the strobe, address and data are registered. They are valid for exactly 1 cycle, the cycle after the final word of the record is consumed. The address equals the record counter value before it increments. Strobes are mutually exclusive.
- Gaps: fifo_rempty_n low mid-record stalls parsing with no state change. Back-to-back words sustain one record per 2/6/5 cycles, with no bubbles.
- Abort: load_kdtree mid-record discards the partial record and issues no write for it. A write strobe already registered in that cycle still appears.
- The upper DATA_WIDTH-IDX_WIDTH bits of the node index word are ignored.
- DONE holds load_done=1 until reset or the next load_kdtree.
- Asynchronous reset mid-load returns the block to IDLE immediately, with outputs 0.

Test Plan:
- Reset then no load_kdtree, FIFO full of words -> fifo_deq stays 0; all strobes 0; state IDLE.
- load_kdtree, words 3,512 -> node_wen 1 cycle after the 512 pop, with node_waddr=0, idx=3, median=512. After 126 words, the next word is treated as leaf element 0.
- Leaf words 1,2,3,4,5,77 (first patch) -> leaf_wen with waddr=0, wpatch=0, patch={5,4,3,2,1} (element 0 in LSBs), idx=77. The 9th patch gives waddr=1, wpatch=0.
- Full stream of 126+3072+2470 words with random fifo_rempty_n gaps -> exactly 63 node, 512 leaf and 494 query writes with in-order addresses; last query_waddr=493; load_done rises 1 cycle after the last query_wen.
- load_kdtree asserted after 3 words of a leaf patch, simultaneous with rempty_n=1 -> no pop that cycle; no leaf_wen for the partial patch; state NODE with node_waddr restarting at 0.
- rst_n low mid-QUERY -> all outputs 0 immediately; after release, IDLE with no pops until load_kdtree.
